instrumented_adder_ripple_wrap: RTL and testbench
=================================================

Name: instrumented_adder_ripple_wrap

Overview:
- Wrapped 32-bit ripple-carry adder with a clocked feedback loop ("pseudo-ring") that measures adder behaviour.
- Selected sum bits are XOR-reduced, inverted and fed back to selected A-operand bits; a counter counts loop toggles.
- Configured and observed through logic-analyzer (LA) buses; two status pins on io.
- Sits in the multi-project harness and is gated by `active`.

Parameters:
- WIDTH, 32, adder/operand/counter width (fixed at 32 in this block).

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- active  in  1  project select; 0 = block isolated.
- la1_data_in  in  32  control: [2:0] addr, [3] write strobe, [4] run.
- la1_data_out  out  32  adder sum S[31:0].
- la1_oenb  in  32  unused.
- la2_data_in  in  32  write data.
- la2_data_out  out  32  toggle counter.
- la2_oenb  in  32  unused.
- la3_data_in  in  32  unused.
- la3_data_out  out  32  readback of register at addr.
- la3_oenb  in  32  unused.
- io_in  in  38  [0] external operand bit; [1] carry-in (optional feature).
- io_out  out  38  [8] chain_out, [9] carry-out; other bits 0.
- io_oeb  out  38  0 on bits 8,9; 1 elsewhere.

Behaviour:
- Registers, all 32 bits:
  - addr 0: a_input.
  - addr 1: b_input.
  - addr 2: a_input_ext_bit_b (ext mask).
  - addr 3: a_input_ring_bit_b (ring mask).
  - addr 4: s_output_bit_b (sum mask).
  - addr 5: control; bit0 = clear counter, self-clearing, reads 0.
  - addr 6–7: read 0, writes ignored.
- Reset (async) clears all registers, chain_out, counter, strobe-history flop. Effect is immediate, including mid-run.
- Write: la1_data_in[3] is sampled each rising edge into strobe_q.
  - The write occurs at the edge where la1_data_in[3]=1 and strobe_q=0 (rising-edge detect).
  - The register addressed by la1_data_in[2:0] loads la2_data_in at that edge; it is visible on outputs the same cycle after the edge.
  - A held strobe writes once.
- Operand A, per bit i:
  - ring_mask[i]=1 → chain_out.
  - else ext_mask[i]=1 → io_in[0].
  - else a_input[i].
  - Ring has priority over ext.
- Adder: {cout,S} = A_eff + b_input + cin, built as an explicit 32-stage ripple chain. cin=0 unless the optional feature is enabled.
- Loop: chain_out_next = run ? ~(^(S & sum_mask)) : 0. run = la1_data_in[4] & active. chain_out is registered on wb_clk_i.
- Counter:
  - Increments on each cycle where chain_out goes 0→1 (rising edge detected against the previous value) and run=1.
  - Wraps at 2^32.
  - Clear (control bit0 write) has priority over increment.
- la3_data_out: combinational mux on la1_data_in[2:0].
- active=0:
  - la*_data_out and io_out driven 0; io_oeb all 1.
  - Writes ignored; loop forced idle (chain_out→0).
  - Registers retained.
- Sum mask 0 with run=1: chain_out settles to 1 (no oscillation), counter increments once then holds.

Optional Feature:
- Macro ADDER_CARRY_IN_EN.
- Defined: cin = io_in[1]. io_oeb[1]=1 (already).
- Undefined: cin=0 and io_in[1] ignored.

Decomposition:
- Package instrumented_adder_pkg: register address constants (ADDR_A..ADDR_CTRL), LA control-bit indices, io pin indices.
- Sub-module ripple_adder: 32 full-adder stages, ports a, b, cin, sum, cout.

Test Plan:
- Reset: assert wb_rst_i mid-run → counter=0, chain_out=0, all readbacks 0 immediately.
- Plain add, active=1: write A=0x0000_0005, B=0xFFFF_FFFD; ring/ext masks 0 → la1_data_out=0x0000_0002, io_out[9]=1.
- Ring oscillation:
  - Set ring_mask=0x80, sum_mask=0x80, A=B=0, run=1 → chain_out toggles every cycle.
  - Counter=5 after 10 cycles from chain_out=0.
  - Clear via addr 5 bit0 → counter=0 next cycle.
- Strobe edge: hold la1_data_in[3]=1 for 4 cycles while la2_data_in changes → register holds only the first value.
- Ext select: ext_mask=0x1, a_input=0, B=0, io_in[0]=1 → S=1; same with ring_mask=0x1, chain_out=0 → S=0 (ring priority).
- Inactive: active=0 → io_oeb=all 1, outputs 0, writes ignored; re-assert active → prior register values read back.

Source files
------------

// File: rtl/instrumented_adder_ripple_wrap_pkg.sv
// Package for instrumented_adder_ripple_wrap.
// Holds the register address map, LA control-bit positions and io pin indices
// shared by the interface, the adder wrapper and its ripple adder.
// Optional build macro used by the top: ADDER_CARRY_IN_EN.
package instrumented_adder_pkg;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned IO_WIDTH = 38;

  // Register map selected by la1_data_in[2:0]
  typedef enum logic [2:0] {
    ADDR_A    = 3'd0,
    ADDR_B    = 3'd1,
    ADDR_EXT  = 3'd2,
    ADDR_RING = 3'd3,
    ADDR_SUM  = 3'd4,
    ADDR_CTRL = 3'd5,
    ADDR_RSV6 = 3'd6,
    ADDR_RSV7 = 3'd7
  } reg_addr_e;

  // la1_data_in control fields
  localparam int unsigned LA1_ADDR_MSB = 2;
  localparam int unsigned LA1_WR_BIT   = 3;
  localparam int unsigned LA1_RUN_BIT  = 4;

  // Control register fields
  localparam int unsigned CTRL_CLR_BIT = 0;

  // io pin indices
  localparam int unsigned IO_EXT_BIT   = 0;
  localparam int unsigned IO_CIN_BIT   = 1;
  localparam int unsigned IO_CHAIN_BIT = 8;
  localparam int unsigned IO_COUT_BIT  = 9;

endpackage

// File: rtl/instrumented_adder_ripple_wrap_if.sv
// Logic-analyzer and io bus bundle for instrumented_adder_ripple_wrap.
// slave  : the adder wrapper (drives *_data_out, io_out, io_oeb)
// master : the harness / testbench (drives *_data_in, *_oenb, io_in)
interface instrumented_adder_ripple_wrap_if;
  import instrumented_adder_pkg::*;

  logic [WIDTH-1:0]    la1_data_in;
  logic [WIDTH-1:0]    la1_data_out;
  logic [WIDTH-1:0]    la1_oenb;
  logic [WIDTH-1:0]    la2_data_in;
  logic [WIDTH-1:0]    la2_data_out;
  logic [WIDTH-1:0]    la2_oenb;
  logic [WIDTH-1:0]    la3_data_in;
  logic [WIDTH-1:0]    la3_data_out;
  logic [WIDTH-1:0]    la3_oenb;
  logic [IO_WIDTH-1:0] io_in;
  logic [IO_WIDTH-1:0] io_out;
  logic [IO_WIDTH-1:0] io_oeb;

  modport master (
    output la1_data_in, la1_oenb, la2_data_in, la2_oenb, la3_data_in, la3_oenb, io_in,
    input  la1_data_out, la2_data_out, la3_data_out, io_out, io_oeb
  );

  modport slave (
    input  la1_data_in, la1_oenb, la2_data_in, la2_oenb, la3_data_in, la3_oenb, io_in,
    output la1_data_out, la2_data_out, la3_data_out, io_out, io_oeb
  );

endinterface

// File: rtl/instrumented_adder_ripple_wrap_ripple_adder.sv
// ripple_adder: WIDTH-stage ripple-carry adder, one full adder per bit.
// Ports: a, b (operands), cin (carry in), sum, cout (carry out).
module ripple_adder
  import instrumented_adder_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  always_comb begin : chain
    logic carry;
    sum   = '0;
    carry = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/instrumented_adder_ripple_wrap.sv
// instrumented_adder_ripple_wrap: 32-bit ripple adder with a clocked
// "pseudo-ring" feedback loop. Masked sum bits are XOR-reduced, inverted and
// fed back into selected A-operand bits; rising edges of the loop are counted.
// Ports:
//   wb_clk_i  system clock
//   wb_rst_i  asynchronous active-high reset
//   active    project select (0 = outputs quiet, writes ignored, loop idle)
//   bus       LA/io bundle: la1 = control/sum, la2 = wdata/counter,
//             la3 = readback, io_in[0] ext bit, io_out[8] chain, io_out[9] cout
// Build option: ADDER_CARRY_IN_EN takes carry-in from io_in[1]; else cin = 0.
module instrumented_adder_ripple_wrap
  import instrumented_adder_pkg::*;
(
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           active,
  instrumented_adder_ripple_wrap_if.slave bus
);

  logic [WIDTH-1:0] a_input;
  logic [WIDTH-1:0] b_input;
  logic [WIDTH-1:0] a_input_ext_bit_b;
  logic [WIDTH-1:0] a_input_ring_bit_b;
  logic [WIDTH-1:0] s_output_bit_b;
  logic [WIDTH-1:0] counter;
  logic             strobe_q;
  logic             chain_out;

  reg_addr_e        addr;
  logic             strobe;
  logic             run;
  logic             wr_en;
  logic             clr;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             cin;
  logic             chain_next;
  logic [WIDTH-1:0] readback;

  assign addr   = reg_addr_e'(bus.la1_data_in[LA1_ADDR_MSB:0]);
  assign strobe = bus.la1_data_in[LA1_WR_BIT];
  assign run    = bus.la1_data_in[LA1_RUN_BIT] & active;
  assign wr_en  = active & strobe & ~strobe_q;
  assign clr    = wr_en && (addr == ADDR_CTRL) && bus.la2_data_in[CTRL_CLR_BIT];

`ifdef ADDER_CARRY_IN_EN
  assign cin = bus.io_in[IO_CIN_BIT];
`else
  assign cin = 1'b0;
`endif

  // Ring select wins over ext select, which wins over the stored operand.
  assign a_eff = (a_input_ring_bit_b & {WIDTH{chain_out}})
               | (~a_input_ring_bit_b & a_input_ext_bit_b & {WIDTH{bus.io_in[IO_EXT_BIT]}})
               | (~a_input_ring_bit_b & ~a_input_ext_bit_b & a_input);

  ripple_adder u_ripple_adder (
    .a    (a_eff),
    .b    (b_input),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  assign chain_next = run ? ~(^(sum & s_output_bit_b)) : 1'b0;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      a_input            <= '0;
      b_input            <= '0;
      a_input_ext_bit_b  <= '0;
      a_input_ring_bit_b <= '0;
      s_output_bit_b     <= '0;
      counter            <= '0;
      strobe_q           <= 1'b0;
      chain_out          <= 1'b0;
    end else begin
      strobe_q  <= strobe;
      chain_out <= chain_next;
      if (wr_en) begin
        case (addr)
          ADDR_A:    a_input            <= bus.la2_data_in;
          ADDR_B:    b_input            <= bus.la2_data_in;
          ADDR_EXT:  a_input_ext_bit_b  <= bus.la2_data_in;
          ADDR_RING: a_input_ring_bit_b <= bus.la2_data_in;
          ADDR_SUM:  s_output_bit_b     <= bus.la2_data_in;
          default:   ;
        endcase
      end
      // Rise is detected against the registered value at the edge it happens.
      if (clr) begin
        counter <= '0;
      end else if (run && chain_next && !chain_out) begin
        counter <= counter + 32'd1;
      end
    end
  end

  always_comb begin
    readback = '0;
    case (addr)
      ADDR_A:    readback = a_input;
      ADDR_B:    readback = b_input;
      ADDR_EXT:  readback = a_input_ext_bit_b;
      ADDR_RING: readback = a_input_ring_bit_b;
      ADDR_SUM:  readback = s_output_bit_b;
      default:   readback = '0;
    endcase
  end

  always_comb begin
    bus.la1_data_out = '0;
    bus.la2_data_out = '0;
    bus.la3_data_out = '0;
    bus.io_out       = '0;
    bus.io_oeb       = '1;
    if (active) begin
      bus.la1_data_out          = sum;
      bus.la2_data_out          = counter;
      bus.la3_data_out          = readback;
      bus.io_out[IO_CHAIN_BIT]  = chain_out;
      bus.io_out[IO_COUT_BIT]   = cout;
      bus.io_oeb[IO_CHAIN_BIT]  = 1'b0;
      bus.io_oeb[IO_COUT_BIT]   = 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{bus.la1_oenb, bus.la2_oenb, bus.la3_oenb, bus.la3_data_in,
                       bus.io_in, bus.la1_data_in[WIDTH-1:LA1_RUN_BIT+1]};

endmodule

// File: tb/tb_instrumented_adder_ripple_wrap.sv
// Directed self-checking bench for instrumented_adder_ripple_wrap.
module tb_instrumented_adder_ripple_wrap;
  import instrumented_adder_pkg::*;

  logic        clk;
  logic        rst;
  logic        active;
  logic [2:0]  addr_v;
  logic        wr_v;
  logic        run_v;
  logic [31:0] wdata;
  logic        ext_v;
  logic        cin_v;

  int n_cmp;
  int n_err;

  localparam logic [37:0] OEB_ACTIVE = 38'h3F_FFFF_FCFF;
  localparam logic [37:0] OEB_IDLE   = 38'h3F_FFFF_FFFF;

  instrumented_adder_ripple_wrap_if bus ();

  assign bus.la1_data_in = {27'd0, run_v, wr_v, addr_v};
  assign bus.la2_data_in = wdata;
  assign bus.la3_data_in = '0;
  assign bus.la1_oenb    = '1;
  assign bus.la2_oenb    = '1;
  assign bus.la3_oenb    = '1;
  assign bus.io_in       = {36'd0, cin_v, ext_v};

  instrumented_adder_ripple_wrap dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .active   (active),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rising edge on the strobe, then release so the next write edge-detects.
  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    addr_v = a;
    wdata  = d;
    wr_v   = 1'b1;
    tick();
    wr_v   = 1'b0;
    tick();
  endtask

  task automatic rd_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    addr_v = a;
    #1;
    check_eq(tag, {32'd0, bus.la3_data_out}, {32'd0, exp});
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    active = 1'b1;
    addr_v = '0;
    wr_v   = 1'b0;
    run_v  = 1'b0;
    wdata  = '0;
    ext_v  = 1'b0;
    cin_v  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_eq("rst_sum",     {32'd0, bus.la1_data_out}, 64'd0);
    check_eq("rst_counter", {32'd0, bus.la2_data_out}, 64'd0);
    check_eq("rst_io_out",  {26'd0, bus.io_out}, 64'd0);
    check_eq("rst_io_oeb",  {26'd0, bus.io_oeb}, {26'd0, OEB_ACTIVE});
    for (int i = 0; i < 8; i++) rd_reg($sformatf("rst_rd%0d", i), 3'(i), 32'd0);

    // Plain add: 5 + 0xFFFFFFFD = 2 with carry out
    wr_reg(3'd0, 32'h0000_0005);
    wr_reg(3'd1, 32'hFFFF_FFFD);
    check_eq("add_sum",  {32'd0, bus.la1_data_out}, 64'h2);
    check_eq("add_io",   {26'd0, bus.io_out}, 64'h200);
    rd_reg("add_rd_a", 3'd0, 32'h0000_0005);
    rd_reg("add_rd_b", 3'd1, 32'hFFFF_FFFD);

    // Held strobe writes only the first data word
    addr_v = 3'd1;
    wr_v   = 1'b1;
    wdata  = 32'h11; tick();
    wdata  = 32'h22; tick();
    wdata  = 32'h33; tick();
    wdata  = 32'h44; tick();
    wr_v   = 1'b0;
    tick();
    rd_reg("strobe_hold", 3'd1, 32'h11);

    // Ext select, then ring priority with chain_out = 0
    wr_reg(3'd0, 32'h0);
    wr_reg(3'd1, 32'h0);
    wr_reg(3'd2, 32'h1);
    ext_v = 1'b1;
    #1;
    check_eq("ext_sum", {32'd0, bus.la1_data_out}, 64'h1);
    wr_reg(3'd3, 32'h1);
    check_eq("ring_prio_sum", {32'd0, bus.la1_data_out}, 64'h0);
    ext_v = 1'b0;

    // Ring oscillation on bit 7
    wr_reg(3'd2, 32'h0);
    wr_reg(3'd3, 32'h80);
    wr_reg(3'd4, 32'h80);
    check_eq("osc_cnt0", {32'd0, bus.la2_data_out}, 64'd0);
    run_v = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_eq($sformatf("osc_chain%0d", k), {63'd0, bus.io_out[8]}, 64'(k % 2));
    end
    check_eq("osc_cnt10", {32'd0, bus.la2_data_out}, 64'd5);
    run_v = 1'b0;
    tick();
    check_eq("osc_hold", {32'd0, bus.la2_data_out}, 64'd5);
    wr_reg(3'd5, 32'h1);
    check_eq("osc_clear", {32'd0, bus.la2_data_out}, 64'd0);
    rd_reg("ctrl_rd", 3'd5, 32'h0);

    // Sum mask 0: chain settles to 1, single increment
    wr_reg(3'd4, 32'h0);
    run_v = 1'b1;
    repeat (5) tick();
    check_eq("mask0_chain", {63'd0, bus.io_out[8]}, 64'd1);
    check_eq("mask0_cnt",   {32'd0, bus.la2_data_out}, 64'd1);
    run_v = 1'b0;
    tick();

    // Inactive: outputs quiet, writes dropped, registers retained
    wr_reg(3'd0, 32'h1234_5678);
    active = 1'b0;
    #1;
    check_eq("idle_la1", {32'd0, bus.la1_data_out}, 64'd0);
    check_eq("idle_la2", {32'd0, bus.la2_data_out}, 64'd0);
    check_eq("idle_la3", {32'd0, bus.la3_data_out}, 64'd0);
    check_eq("idle_io",  {26'd0, bus.io_out}, 64'd0);
    check_eq("idle_oeb", {26'd0, bus.io_oeb}, {26'd0, OEB_IDLE});
    wr_reg(3'd0, 32'hDEAD_BEEF);
    active = 1'b1;
    #1;
    rd_reg("idle_keep_a",   3'd0, 32'h1234_5678);
    rd_reg("idle_keep_sum", 3'd4, 32'h0);
    check_eq("idle_keep_cnt", {32'd0, bus.la2_data_out}, 64'd1);

    // Asynchronous reset in the middle of a run
    wr_reg(3'd0, 32'h0);
    wr_reg(3'd4, 32'h80);
    run_v = 1'b1;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_cnt",   {32'd0, bus.la2_data_out}, 64'd0);
    check_eq("mid_rst_chain", {63'd0, bus.io_out[8]}, 64'd0);
    for (int i = 0; i < 5; i++) rd_reg($sformatf("mid_rst_rd%0d", i), 3'(i), 32'd0);
    run_v = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
